alu_issue_stage: RTL and testbench

- Decode/issue stage that produces the ALU's operand interface (a, b, 3-bit alu_op) from RV32I instructions.
- Accepts one instruction per cycle from fetch over a valid/ready handshake.
- Reads the register file and builds operands and control signals, then holds them in a single registered ID/EX slot.
- Supports downstream backpressure and pipeline flush.

---
 rtl/alu_issue_stage.sv | 195 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/issue into a single registered ID/EX slot.
// Builds ALU operands (a, b, alu_op) and side-effect controls from the
// instruction offered by fetch, with valid/ready backpressure and flush.
module alu_issue_stage #(
   parameter int XLEN           = 32,
   parameter bit ILLEGAL_AS_NOP = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_a,
   output logic [XLEN-1:0] ex_b,
   output logic [2:0]      ex_alu_op,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_branch,
   output logic            ex_branch_ne,
   output logic [XLEN-1:0] ex_store_data,
   output logic [XLEN-1:0] ex_pc,
   output logic            ex_illegal
);

   localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                          OP_OR  = 3'b011, OP_XOR = 3'b100, OP_SLL = 3'b101,
                          OP_SRL = 3'b110, OP_SLT = 3'b111;

   localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LD = 7'b0000011,
                          OPC_ST = 7'b0100011, OPC_BR = 7'b1100011, OPC_LUI = 7'b0110111;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [2:0]      alu_op;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            branch;
      logic            branch_ne;
      logic [XLEN-1:0] store_data;
      logic [XLEN-1:0] pc;
      logic            illegal;
   } slot_t;

   slot_t dec;
   slot_t slot_d, slot_q;
   logic  ill;
   logic  accept;

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_s, imm_u;

   // Shared funct3 -> ALU op map for R-type and I-type ALU instructions.
   function automatic logic [2:0] f3_op(input logic [2:0] fn3);
      case (fn3)
         3'b000:  f3_op = OP_ADD;
         3'b100:  f3_op = OP_XOR;
         3'b110:  f3_op = OP_OR;
         3'b111:  f3_op = OP_AND;
         3'b001:  f3_op = OP_SLL;
         3'b101:  f3_op = OP_SRL;
         3'b010:  f3_op = OP_SLT;
         default: f3_op = OP_ADD;
      endcase
   endfunction

   assign opc      = if_instr[6:0];
   assign f3       = if_instr[14:12];
   assign f7       = if_instr[31:25];
   assign rs1_addr = if_instr[19:15];
   assign rs2_addr = if_instr[24:20];
   assign imm_i    = {{20{if_instr[31]}}, if_instr[31:20]};
   assign imm_s    = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
   assign imm_u    = {if_instr[31:12], 12'b0};

   assign if_ready = !slot_q.valid || ex_ready;
   assign accept   = if_valid && if_ready;

   // Decode the offered instruction into a candidate slot entry.
   always_comb begin
      dec       = '0;
      ill       = 1'b0;
      dec.valid = 1'b1;
      dec.pc    = if_pc;
      dec.rd    = if_instr[11:7];
      case (opc)
         OPC_R: begin
            dec.a         = rs1_data;
            dec.b         = rs2_data;
            dec.reg_write = 1'b1;
            if (f7 == 7'b0 && f3 != 3'b011)          dec.alu_op = f3_op(f3);
            else if (f7 == 7'b0100000 && f3 == 3'b0) dec.alu_op = OP_SUB;
            else                                     ill = 1'b1;
         end
         OPC_I: begin
            dec.a         = rs1_data;
            dec.b         = imm_i;
            dec.reg_write = 1'b1;
            // SLTIU is unsupported; shifts need a clean funct7 (no SRAI).
            if (f3 == 3'b011 || ((f3 == 3'b001 || f3 == 3'b101) && f7 != 7'b0)) ill = 1'b1;
            else dec.alu_op = f3_op(f3);
         end
         OPC_LD: begin
            dec.a         = rs1_data;
            dec.b         = imm_i;
            dec.mem_read  = 1'b1;
            dec.reg_write = 1'b1;
            ill           = (f3 != 3'b010);
         end
         OPC_ST: begin
            dec.a          = rs1_data;
            dec.b          = imm_s;
            dec.mem_write  = 1'b1;
            dec.store_data = rs2_data;
            ill            = (f3 != 3'b010);
         end
         OPC_BR: begin
            dec.a         = rs1_data;
            dec.b         = rs2_data;
            dec.alu_op    = OP_SUB;
            dec.branch    = 1'b1;
            dec.branch_ne = f3[0];
            ill           = (f3[2:1] != 2'b00);
         end
         OPC_LUI: begin
            dec.b         = imm_u;
            dec.reg_write = 1'b1;
         end
         default: ill = 1'b1;
      endcase
      // Illegal encodings issue as ADD 0+0; optionally with no side effects.
      if (ill) begin
         dec.illegal    = 1'b1;
         dec.alu_op     = OP_ADD;
         dec.a          = '0;
         dec.b          = '0;
         dec.store_data = '0;
         if (ILLEGAL_AS_NOP) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.branch_ne = 1'b0;
         end
      end
      if (dec.rd == 5'd0) dec.reg_write = 1'b0;
   end

   // Slot next state: load on accept (killed by flush), drop on consume/flush.
   always_comb begin
      slot_d = slot_q;
      if (accept) begin
         slot_d       = dec;
         slot_d.valid = !flush;
      end else if (flush || ex_ready) begin
         slot_d.valid = 1'b0;
      end
   end

   // ID/EX slot register; reset clears every field.
   always_ff @(posedge clk) begin
      if (rst) slot_q <= '0;
      else     slot_q <= slot_d;
   end

   assign ex_valid      = slot_q.valid;
   assign ex_a          = slot_q.a;
   assign ex_b          = slot_q.b;
   assign ex_alu_op     = slot_q.alu_op;
   assign ex_rd         = slot_q.rd;
   assign ex_reg_write  = slot_q.reg_write;
   assign ex_mem_read   = slot_q.mem_read;
   assign ex_mem_write  = slot_q.mem_write;
   assign ex_branch     = slot_q.branch;
   assign ex_branch_ne  = slot_q.branch_ne;
   assign ex_store_data = slot_q.store_data;
   assign ex_pc         = slot_q.pc;
   assign ex_illegal    = slot_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed, table-driven bench for alu_issue_stage.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst, if_valid, if_ready, flush, ex_valid, ex_ready;
   logic [31:0] if_instr, if_pc, rs1_data, rs2_data;
   logic [4:0]  rs1_addr, rs2_addr, ex_rd;
   logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
   logic [2:0]  ex_alu_op;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch_ne, ex_illegal;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .ex_valid(ex_valid),
      .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_store_data(ex_store_data),
      .ex_pc(ex_pc), .ex_illegal(ex_illegal)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] a, b;
      logic [2:0]  op;
      logic [4:0]  rd;
      logic        rw, mr, mw, br, bne;
      logic [31:0] sd, pc;
      logic        ill;
   } out_t;

   typedef struct {
      logic [31:0] instr, r1, r2;
      out_t        e;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   out_t got;

   assign got = '{valid: ex_valid, a: ex_a, b: ex_b, op: ex_alu_op, rd: ex_rd,
                  rw: ex_reg_write, mr: ex_mem_read, mw: ex_mem_write, br: ex_branch,
                  bne: ex_branch_ne, sd: ex_store_data, pc: ex_pc, ill: ex_illegal};

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   // ctl = {rw, mr, mw, br, bne, ill}; pc is filled in when the vector is applied.
   function automatic vec_t v(input logic [31:0] ins, r1, r2, ea, eb, input logic [2:0] op,
                              input logic [4:0] rd, input logic [5:0] ctl, input logic [31:0] sd);
      vec_t t;
      t.instr = ins; t.r1 = r1; t.r2 = r2;
      t.e = '{valid: 1'b1, a: ea, b: eb, op: op, rd: rd, rw: ctl[5], mr: ctl[4], mw: ctl[3],
              br: ctl[2], bne: ctl[1], sd: sd, pc: 32'h0, ill: ctl[0]};
      return t;
   endfunction

   vec_t tbl[22];
   out_t e;

   task automatic drive(input logic [31:0] ins, r1, r2, pc);
      if_valid = 1'b1; if_instr = ins; rs1_data = r1; rs2_data = r2; if_pc = pc;
   endtask

   initial begin
      tbl[0]  = v(32'h002081B3, 5, 7, 5, 7, 3'd0, 3, 6'b100000, 0);                 // ADD
      tbl[1]  = v(32'h402081B3, 10, 3, 10, 3, 3'd1, 3, 6'b100000, 0);               // SUB
      tbl[2]  = v(32'hFFF00093, 0, 32'h55, 0, 32'hFFFFFFFF, 3'd0, 1, 6'b100000, 0); // ADDI -1
      tbl[3]  = v(32'h0020A423, 32'h100, 32'hDEADBEEF, 32'h100, 8, 3'd0, 8, 6'b001000, 32'hDEADBEEF); // SW
      tbl[4]  = v(32'h4020D1B3, 9, 2, 0, 0, 3'd0, 3, 6'b000001, 0);                 // SRA illegal
      tbl[5]  = v(32'hFFC12283, 32'h1000, 0, 32'h1000, 32'hFFFFFFFC, 3'd0, 5, 6'b110000, 0); // LW
      tbl[6]  = v(32'h00209463, 4, 4, 4, 4, 3'd1, 8, 6'b000110, 0);                 // BNE
      tbl[7]  = v(32'h00208463, 4, 6, 4, 6, 3'd1, 8, 6'b000100, 0);                 // BEQ
      tbl[8]  = v(32'h123453B7, 32'hAAAA, 0, 0, 32'h12345000, 3'd0, 7, 6'b100000, 0); // LUI
      tbl[9]  = v(32'h00208033, 1, 2, 1, 2, 3'd0, 0, 6'b000000, 0);                 // ADD rd=x0
      tbl[10] = v(32'h0010B093, 3, 0, 0, 0, 3'd0, 1, 6'b000001, 0);                 // SLTIU illegal
      tbl[11] = v(32'h0F00C213, 32'hFF, 0, 32'hFF, 32'hF0, 3'd4, 4, 6'b100000, 0);  // XORI
      tbl[12] = v(32'h00309293, 1, 0, 1, 3, 3'd5, 5, 6'b100000, 0);                 // SLLI
      tbl[13] = v(32'h4030D293, 1, 0, 0, 0, 3'd0, 5, 6'b000001, 0);                 // SRAI illegal
      tbl[14] = v(32'h0020E1B3, 32'hC, 3, 32'hC, 3, 3'd3, 3, 6'b100000, 0);         // OR
      tbl[15] = v(32'h0020F1B3, 32'hC, 3, 32'hC, 3, 3'd2, 3, 6'b100000, 0);         // AND
      tbl[16] = v(32'h0020A1B3, 1, 2, 1, 2, 3'd7, 3, 6'b100000, 0);                 // SLT
      tbl[17] = v(32'h0020D1B3, 8, 1, 8, 1, 3'd6, 3, 6'b100000, 0);                 // SRL
      tbl[18] = v(32'h0000006F, 1, 1, 0, 0, 3'd0, 0, 6'b000001, 0);                 // JAL illegal
      tbl[19] = v(32'h00011283, 1, 1, 0, 0, 3'd0, 5, 6'b000001, 0);                 // LH illegal
      tbl[20] = v(32'h0020C463, 1, 1, 0, 0, 3'd0, 8, 6'b000001, 0);                 // BLT illegal
      tbl[21] = v(32'hFE20AE23, 32'h200, 32'h12, 32'h200, 32'hFFFFFFFC, 3'd0, 28, 6'b001000, 32'h12); // SW -4

      rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
      if_valid = 1'b0; if_instr = '0; if_pc = '0; rs1_data = '0; rs2_data = '0;
      @(negedge clk); @(negedge clk);
      chk("reset_outputs", got, '0);
      chk("reset_if_ready", if_ready, 1'b1);
      rst = 1'b0;

      // Back-to-back vectors at full throughput.
      ex_ready = 1'b1;
      for (int i = 0; i < 22; i++) begin
         logic [31:0] ins;
         ins = tbl[i].instr;
         drive(ins, tbl[i].r1, tbl[i].r2, 32'h1000 + 32'(4 * i));
         #1;
         chk($sformatf("rs_addr%0d", i), {rs1_addr, rs2_addr}, {ins[19:15], ins[24:20]});
         chk($sformatf("if_ready%0d", i), if_ready, 1'b1);
         @(negedge clk);
         e = tbl[i].e; e.pc = 32'h1000 + 32'(4 * i);
         chk($sformatf("vec%0d", i), got, e);
      end

      // Consume without a new accept.
      if_valid = 1'b0;
      @(negedge clk);
      chk("consume_drop", ex_valid, 1'b0);

      // Backpressure: ADD held for 3 stalled cycles while fetch offers SUB.
      drive(32'h002081B3, 5, 7, 32'h2000);
      @(negedge clk);
      e = tbl[0].e; e.pc = 32'h2000;
      ex_ready = 1'b0;
      drive(32'h402081B3, 1, 1, 32'h2004);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stall_if_ready%0d", k), if_ready, 1'b0);
         chk($sformatf("stall_hold%0d", k), got, e);
         @(negedge clk);
      end

      // Flush while stalled with a new offer.
      flush = 1'b1;
      @(negedge clk);
      chk("flush_stalled", ex_valid, 1'b0);
      flush = 1'b0; if_valid = 1'b0;
      @(negedge clk);
      chk("flush_stalled_after", ex_valid, 1'b0);

      // Flush with ex_ready=1: the same-cycle offer is accepted and discarded.
      ex_ready = 1'b1;
      drive(32'h002081B3, 5, 7, 32'h3000);
      @(negedge clk);
      chk("preflush_valid", ex_valid, 1'b1);
      drive(32'h0020C1B3, 6, 3, 32'h3004);
      flush = 1'b1;
      #1;
      chk("flush_if_ready", if_ready, 1'b1);
      @(negedge clk);
      chk("flush_accept_drop", ex_valid, 1'b0);
      flush = 1'b0; if_valid = 1'b0;
      @(negedge clk);
      chk("flush_accept_after", ex_valid, 1'b0);

      // Reset mid-stream while stalled, with flush and an offer also present.
      drive(32'h002081B3, 5, 7, 32'h4000);
      @(negedge clk);
      chk("prerst_valid", ex_valid, 1'b1);
      ex_ready = 1'b0; rst = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("midrst_outputs", got, '0);
      chk("midrst_if_ready", if_ready, 1'b1);
      rst = 1'b0; flush = 1'b0; if_valid = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
